// File: rtl/pair_inverse_pkg.sv
// Purpose: shared types and widths for the pair_inverse preimage scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: scan FSM state enum, candidate index / match counter / operand widths.
package pair_inverse_pkg;

    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
    localparam int OP_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/pair_inverse_if.sv
// Purpose: request/result bundle between a scan requester and pair_inverse.
// Latency: none (wires only).
// Backpressure: out_ready from the master stalls the slave's result register.
// Ports: start/target (request), busy/done (status), out_valid/out_ready/out_a/out_b
//        (result handshake), match_count only when PAIR_INVERSE_COUNT_EN is defined.
interface pair_inverse_if;
    import pair_inverse_pkg::*;

    logic            start;
    logic [OP_W-1:0] target;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_a;
    logic [OP_W-1:0] out_b;
    logic            done;
`ifdef PAIR_INVERSE_COUNT_EN
    logic [CNT_W-1:0] match_count;

    modport master (output start, target, out_ready,
                    input  busy, out_valid, out_a, out_b, done, match_count);
    modport slave  (input  start, target, out_ready,
                    output busy, out_valid, out_a, out_b, done, match_count);
`else
    modport master (output start, target, out_ready,
                    input  busy, out_valid, out_a, out_b, done);
    modport slave  (input  start, target, out_ready,
                    output busy, out_valid, out_a, out_b, done);
`endif

endinterface

// File: rtl/pair_func.sv
// Purpose: forward function c = F(a,b) whose preimages pair_inverse searches for.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (operands, p=a[1] q=a[0] r=b[1] s=b[0]) -> c (result).
module pair_func
    import pair_inverse_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] c
);

    logic p, q, r, s;

    assign p = a[1];
    assign q = a[0];
    assign r = b[1];
    assign s = b[0];

    assign c[1] = (~p & r & s) | (~p & q & r) | (p & ~r);
    assign c[0] = (p | q | s) & (q | r) & (~p | r) & (~p | r | s);

endmodule

// File: rtl/pair_inverse.sv
// Purpose: scan all 16 (a,b) candidates and stream every pair with F(a,b)==target.
// Latency: start accepted at N, first candidate evaluated at N+1, its match valid at N+2.
// Backpressure: out_valid&~out_ready freezes the candidate index and result (HOLD).
// Ports: clk, rst_n (sync, active-low), bus (pair_inverse_if.slave).
// Parameter DESC: 0 scans idx 0..15, 1 scans idx 15..0; idx = {a, b}.
// Optional PAIR_INVERSE_COUNT_EN adds bus.match_count (accepted transfers this scan).
module pair_inverse
    import pair_inverse_pkg::*;
#(
    parameter bit DESC = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    pair_inverse_if.slave bus
);

    localparam logic [IDX_W-1:0] FIRST_IDX = DESC ? {IDX_W{1'b1}} : {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX  = DESC ? {IDX_W{1'b0}} : {IDX_W{1'b1}};

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [OP_W-1:0]  tgt;
    logic [OP_W-1:0]  c;
    logic [OP_W-1:0]  out_a_q;
    logic [OP_W-1:0]  out_b_q;
    logic             out_valid_q;
    logic             scan_end;   // every idx evaluated; only a pending result is left
    logic             stall;
    logic             hit;

    pair_func u_func (
        .a (idx[IDX_W-1:OP_W]),
        .b (idx[OP_W-1:0]),
        .c (c)
    );

    assign hit      = (c == tgt);
    assign stall    = out_valid_q & ~bus.out_ready;
    assign next_idx = DESC ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));

    // SCAN and HOLD share one datapath: HOLD is simply "the result register was
    // blocked", and on release it evaluates the idx that was frozen while blocked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            tgt         <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            scan_end    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt      <= bus.target;
                        idx      <= FIRST_IDX;
                        scan_end <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN, HOLD: begin
                    if (stall) begin
                        state <= HOLD;
                    end else if (scan_end) begin
                        // Last match has just been taken (or was never loaded).
                        out_valid_q <= 1'b0;
                        state       <= FIN;
                    end else begin
                        out_valid_q <= hit;
                        if (hit) begin
                            out_a_q <= idx[IDX_W-1:OP_W];
                            out_b_q <= idx[OP_W-1:0];
                        end
                        if (idx == LAST_IDX) begin
                            // No wrap; a final match still has to be drained.
                            scan_end <= 1'b1;
                            state    <= hit ? SCAN : FIN;
                        end else begin
                            idx   <= next_idx;
                            state <= SCAN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state == SCAN) || (state == HOLD);
    assign bus.done      = (state == FIN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;

`ifdef PAIR_INVERSE_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
    logic             xfer;

    assign xfer = out_valid_q & bus.out_ready;

    // start is only honoured in IDLE, where no result can be pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if ((state == IDLE) && bus.start) begin
            match_cnt <= '0;
        end else if (xfer) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign bus.match_count = match_cnt;
`endif

endmodule

// File: tb/tb_pair_inverse.sv
// Purpose: directed self-checking bench for pair_inverse (DESC=0 and DESC=1 instances).
// Latency: checks first-result latency and done/busy timing against hand-derived cycles.
// Backpressure: drives out_ready low for a fixed number of cycles per result in the stall test.
// match_count is checked only when PAIR_INVERSE_COUNT_EN is defined.
module tb_pair_inverse;
    import pair_inverse_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] target;
    logic       out_ready;
    logic       cur_sel;

    int vectors;
    int miscompares;

    logic [3:0] got_pair [0:15];
    int         got_n;
    int         done_n;
    int         unstable_n;
    int         first_cyc;
    int         busy_bad;

    logic [1:0] fa, fb, fc;

    pair_inverse_if if0 ();
    pair_inverse_if if1 ();

    assign if0.start     = start & ~cur_sel;
    assign if1.start     = start & cur_sel;
    assign if0.target    = target;
    assign if1.target    = target;
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    pair_inverse #(.DESC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pair_inverse #(.DESC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    pair_func u_ref (.a(fa), .b(fb), .c(fc));

    logic       m_valid, m_busy, m_done;
    logic [1:0] m_a, m_b;
    assign m_valid = cur_sel ? if1.out_valid : if0.out_valid;
    assign m_busy  = cur_sel ? if1.busy      : if0.busy;
    assign m_done  = cur_sel ? if1.done      : if0.done;
    assign m_a     = cur_sel ? if1.out_a     : if0.out_a;
    assign m_b     = cur_sel ? if1.out_b     : if0.out_b;
`ifdef PAIR_INVERSE_COUNT_EN
    logic [4:0] m_count;
    assign m_count = cur_sel ? if1.match_count : if0.match_count;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Issues start on the selected instance and records every accepted transfer.
    // Cycle 1 is the cycle right after the edge that accepted start.
    task automatic run_scan(input logic sel, input logic [1:0] tgt,
                            input int stall_n, input int repulse_at);
        int cyc;
        int post;
        int hold_cnt;
        logic [3:0] held;
        for (int i = 0; i < 16; i++) got_pair[i] = 'x;
        got_n = 0; done_n = 0; unstable_n = 0; first_cyc = -1; busy_bad = 0;
        cur_sel   = sel;
        target    = tgt;
        start     = 1'b1;
        out_ready = (stall_n == 0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; post = 0; hold_cnt = 0; held = '0;
        while (cyc < 400 && post < 4) begin
            start = (cyc == repulse_at);
            target = start ? ~tgt : tgt;
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (hold_cnt > 0 && {m_a, m_b} !== held) unstable_n++;
                held = {m_a, m_b};
                if (hold_cnt < stall_n) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                    if (got_n < 16) got_pair[got_n] = {m_a, m_b};
                    got_n++;
                    hold_cnt = 0;
                end
            end else begin
                out_ready = (stall_n == 0);
            end
            if (m_done) begin
                done_n++;
                if (m_busy) busy_bad++;
            end
            if (done_n > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        target = tgt;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; target = 2'b00; out_ready = 1'b0; cur_sel = 1'b0;
        fa = 2'b00; fb = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (if0.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy0: got %b expected 0", if0.busy); end
        vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid0: got %b expected 0", if0.out_valid); end
        vectors++; if (if0.done !== 1'b0) begin miscompares++; $display("FAIL rst_done0: got %b expected 0", if0.done); end
        vectors++; if ({if0.out_a, if0.out_b} !== 4'b0000) begin miscompares++; $display("FAIL rst_out0: got %b expected 0000", {if0.out_a, if0.out_b}); end
        vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy1: got %b expected 0", if1.busy); end
        vectors++; if (if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid1: got %b expected 0", if1.out_valid); end
        vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL rst_done1: got %b expected 0", if1.done); end
        vectors++; if ({if1.out_a, if1.out_b} !== 4'b0000) begin miscompares++; $display("FAIL rst_out1: got %b expected 0000", {if1.out_a, if1.out_b}); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (if0.match_count !== 5'd0) begin miscompares++; $display("FAIL rst_count0: got %0d expected 0", if0.match_count); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_func;
        logic [1:0] ftab [0:15];
        ftab = '{2'b00, 2'b00, 2'b00, 2'b11,
                 2'b01, 2'b01, 2'b11, 2'b11,
                 2'b10, 2'b10, 2'b01, 2'b01,
                 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 16; i++) begin
            {fa, fb} = 4'(i);
            #1;
            vectors++;
            if (fc !== ftab[i]) begin
                miscompares++;
                $display("FAIL func_%0d: got %b expected %b", i, fc, ftab[i]);
            end
        end
    endtask

    task automatic test_asc_t00;
        logic [3:0] exp [0:2];
        exp = '{4'b0000, 4'b0001, 4'b0010};
        run_scan(1'b0, 2'b00, 0, 0);
        vectors++; if (got_n !== 3) begin miscompares++; $display("FAIL asc_count: got %0d expected 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got_pair[i] !== exp[i]) begin miscompares++; $display("FAIL asc_pair%0d: got %b expected %b", i, got_pair[i], exp[i]); end
        end
        vectors++; if (first_cyc !== 2) begin miscompares++; $display("FAIL asc_latency: got %0d expected 2", first_cyc); end
        vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL asc_done: got %0d expected 1", done_n); end
        vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL asc_busy_at_done: got %0d expected 0", busy_bad); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (m_count !== 5'd3) begin miscompares++; $display("FAIL asc_match_count: got %0d expected 3", m_count); end
`endif
    endtask

    task automatic test_desc_t01;
        logic [3:0] exp [0:5];
        exp = '{4'b1111, 4'b1110, 4'b1011, 4'b1010, 4'b0101, 4'b0100};
        run_scan(1'b1, 2'b01, 0, 0);
        vectors++; if (got_n !== 6) begin miscompares++; $display("FAIL desc_count: got %0d expected 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_pair[i] !== exp[i]) begin miscompares++; $display("FAIL desc_pair%0d: got %b expected %b", i, got_pair[i], exp[i]); end
        end
        vectors++; if (first_cyc !== 2) begin miscompares++; $display("FAIL desc_latency: got %0d expected 2", first_cyc); end
        vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL desc_done: got %0d expected 1", done_n); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (m_count !== 5'd6) begin miscompares++; $display("FAIL desc_match_count: got %0d expected 6", m_count); end
`endif
    endtask

    task automatic test_stall_t10;
        logic [3:0] exp [0:3];
        exp = '{4'b1000, 4'b1001, 4'b1100, 4'b1101};
        run_scan(1'b0, 2'b10, 3, 0);
        vectors++; if (got_n !== 4) begin miscompares++; $display("FAIL stall_count: got %0d expected 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_pair[i] !== exp[i]) begin miscompares++; $display("FAIL stall_pair%0d: got %b expected %b", i, got_pair[i], exp[i]); end
        end
        vectors++; if (first_cyc !== 10) begin miscompares++; $display("FAIL stall_latency: got %0d expected 10", first_cyc); end
        vectors++; if (unstable_n !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes expected 0", unstable_n); end
        vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL stall_done: got %0d expected 1", done_n); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (m_count !== 5'd4) begin miscompares++; $display("FAIL stall_match_count: got %0d expected 4", m_count); end
`endif
    endtask

    task automatic test_repulse_t11;
        logic [3:0] exp [0:2];
        exp = '{4'b0011, 4'b0110, 4'b0111};
        run_scan(1'b0, 2'b11, 0, 4);
        vectors++; if (got_n !== 3) begin miscompares++; $display("FAIL repulse_count: got %0d expected 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got_pair[i] !== exp[i]) begin miscompares++; $display("FAIL repulse_pair%0d: got %b expected %b", i, got_pair[i], exp[i]); end
        end
        vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL repulse_done: got %0d expected 1", done_n); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (m_count !== 5'd3) begin miscompares++; $display("FAIL repulse_match_count: got %0d expected 3", m_count); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        int cyc;
        int dn;
        logic [3:0] exp [0:2];
        exp = '{4'b0011, 4'b0110, 4'b0111};
        cur_sel = 1'b0; target = 2'b01; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0; cyc = 0; dn = 0;
        while (n < 2 && cyc < 100) begin
            if (m_valid && out_ready) n++;
            if (m_done) dn++;
            @(posedge clk); #1;
            cyc++;
        end
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL rstmid_partial: got %0d transfers expected 2", n); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        if (m_done) dn++;
        vectors++; if (m_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", m_busy); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b expected 0", m_valid); end
        vectors++; if (dn !== 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d expected 0", dn); end
`ifdef PAIR_INVERSE_COUNT_EN
        vectors++; if (m_count !== 5'd0) begin miscompares++; $display("FAIL rstmid_match_count: got %0d expected 0", m_count); end
`endif
        rst_n = 1'b1;
        run_scan(1'b0, 2'b11, 0, 0);
        vectors++; if (got_n !== 3) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got_pair[i] !== exp[i]) begin miscompares++; $display("FAIL rstmid_pair%0d: got %b expected %b", i, got_pair[i], exp[i]); end
        end
        // idx 3 is the first hit, so valid in cycle 5 only if start was taken right after reset.
        vectors++; if (first_cyc !== 5) begin miscompares++; $display("FAIL rstmid_latency: got %0d expected 5", first_cyc); end
        vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL rstmid_done: got %0d expected 1", done_n); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_func();
        test_asc_t00();
        test_desc_t01();
        test_stall_t10();
        test_repulse_t11();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
